// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style cascade controller.
package pic_pkg;

  localparam int unsigned CAS_W = 3;
  localparam int unsigned IR_N  = 2 ** CAS_W;

  typedef logic [CAS_W-1:0] cas_id_t;

  typedef enum logic [1:0] {
    MODE_SINGLE,
    MODE_MASTER,
    MODE_SLAVE
  } mode_e;

  function automatic mode_e decode_mode(input logic sngl, input logic sp);
    if (sngl)    return MODE_SINGLE;
    else if (sp) return MODE_MASTER;
    else         return MODE_SLAVE;
  endfunction

endpackage

// File: rtl/cascade_ctrl.sv
// Cascade-bus controller: master drives CAS with the active IR, slave matches CAS against its ID.
// Optional CAS_LATCH_EN: master holds the location captured at the start of an acknowledge.
module cascade_ctrl
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sp,
  input  logic               sngl,
  input  logic [IR_N-1:0]    icw3,
  input  logic [CAS_W-1:0]   interrupt_location,
  input  logic               interrupt_exists,
  inout  wire  [CAS_W-1:0]   cas,
  output logic               address_write_enable
);

  mode_e   mode;
  cas_id_t eff_loc;

  logic    awe_d, awe_q;
  logic    cas_oe_d, cas_oe_q;
  cas_id_t cas_drv_d, cas_drv_q;

`ifdef CAS_LATCH_EN
  logic    held_d, held_q;
  cas_id_t hold_d, hold_q;

  // The first acknowledge cycle uses the live location; later cycles use the held copy.
  always_comb begin
    held_d  = interrupt_exists;
    hold_d  = '0;
    eff_loc = interrupt_location;
    if (interrupt_exists) begin
      hold_d = held_q ? hold_q : interrupt_location;
    end
    if (held_q) begin
      eff_loc = hold_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= 1'b0;
      hold_q <= '0;
    end else begin
      held_q <= held_d;
      hold_q <= hold_d;
    end
  end
`else
  always_comb begin
    eff_loc = interrupt_location;
  end
`endif

  always_comb begin
    mode      = decode_mode(sngl, sp);
    awe_d     = 1'b0;
    cas_oe_d  = 1'b0;
    cas_drv_d = '0;
    case (mode)
      MODE_SINGLE: begin
        awe_d = interrupt_exists;
      end
      MODE_MASTER: begin
        cas_oe_d  = interrupt_exists;
        cas_drv_d = eff_loc;
        awe_d     = interrupt_exists & ~icw3[eff_loc];
      end
      MODE_SLAVE: begin
        // An X/Z bit on the bus makes the compare unknown, which lands in the else branch.
        if (cas == icw3[CAS_W-1:0]) begin
          awe_d = interrupt_exists;
        end else begin
          awe_d = 1'b0;
        end
      end
      default: begin
        awe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awe_q     <= 1'b0;
      cas_oe_q  <= 1'b0;
      cas_drv_q <= '0;
    end else begin
      awe_q     <= awe_d;
      cas_oe_q  <= cas_oe_d;
      cas_drv_q <= cas_drv_d;
    end
  end

  assign cas                  = cas_oe_q ? cas_drv_q : 'z;
  assign address_write_enable = awe_q;

endmodule

// File: tb/tb_cascade_ctrl.sv
// Bench: one master (slaves on IR0/IR3) and two slaves (IDs 0 and 3) sharing a pulled-up CAS bus.
module tb_cascade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_ie;
  logic [2:0] m_loc;
  logic       m_sngl;
  logic       m_awe, s0_awe, s3_awe;
  wire  [2:0] cas_bus;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // A released bus resolves to 3'b111, an ID no slave here owns.
  pullup (cas_bus[0]);
  pullup (cas_bus[1]);
  pullup (cas_bus[2]);

  always #5 clk = ~clk;

  cascade_ctrl u_master (
    .clk(clk), .rst_n(rst_n), .sp(1'b1), .sngl(m_sngl), .icw3(8'b0000_1001),
    .interrupt_location(m_loc), .interrupt_exists(m_ie), .cas(cas_bus),
    .address_write_enable(m_awe)
  );

  cascade_ctrl u_slave0 (
    .clk(clk), .rst_n(rst_n), .sp(1'b0), .sngl(1'b0), .icw3(8'b1111_1000),
    .interrupt_location(3'd5), .interrupt_exists(1'b1), .cas(cas_bus),
    .address_write_enable(s0_awe)
  );

  cascade_ctrl u_slave3 (
    .clk(clk), .rst_n(rst_n), .sp(1'b0), .sngl(1'b0), .icw3(8'b0000_0011),
    .interrupt_location(3'd6), .interrupt_exists(1'b1), .cas(cas_bus),
    .address_write_enable(s3_awe)
  );

  typedef struct {
    logic       ie;
    logic [2:0] loc;
    logic       sngl;
    logic [2:0] bus;
    logic       awe_m;
    logic       awe_s0;
    logic       awe_s3;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] bus, input logic am,
                         input logic a0, input logic a3);
    chk({tag, ".cas"},    cas_bus,        bus);
    chk({tag, ".awe_m"},  {2'b00, m_awe},  {2'b00, am});
    chk({tag, ".awe_s0"}, {2'b00, s0_awe}, {2'b00, a0});
    chk({tag, ".awe_s3"}, {2'b00, s3_awe}, {2'b00, a3});
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 3'd3, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 3'd1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 3'd2, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd6, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 3'd3, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 3'd3, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0};

    rst_n  = 1'b0;
    m_ie   = 1'b0;
    m_loc  = 3'd0;
    m_sngl = 1'b0;
    @(negedge clk);
    chk_all("in_reset", 3'b111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk_all("after_reset", 3'b111, 1'b0, 1'b0, 1'b0);

    // Latency: master output one edge after its inputs, slave one edge after the bus.
    m_ie  = 1'b1;
    m_loc = 3'd3;
    tick();
    chk_all("lat1", 3'b011, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("lat2", 3'b011, 1'b0, 1'b0, 1'b1);

    m_loc = 3'd0;
    tick();
`ifdef CAS_LATCH_EN
    chk_all("loc_chg0", 3'b011, 1'b0, 1'b0, 1'b1);
`else
    chk_all("loc_chg0", 3'b000, 1'b0, 1'b0, 1'b1);
`endif
    m_loc = 3'd1;
    tick();
`ifdef CAS_LATCH_EN
    chk_all("loc_chg1", 3'b011, 1'b0, 1'b0, 1'b1);
`else
    chk_all("loc_chg1", 3'b001, 1'b1, 1'b1, 1'b0);
`endif

    m_ie = 1'b0;
    tick();
    chk("fall.cas",   cas_bus,        3'b111);
    chk("fall.awe_m", {2'b00, m_awe}, 3'b000);
    tick();
    chk_all("fall2", 3'b111, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      m_ie   = 1'b0;
      m_sngl = 1'b0;
      tick();
      tick();
      m_ie   = vecs[i].ie;
      m_loc  = vecs[i].loc;
      m_sngl = vecs[i].sngl;
      tick();
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].bus, vecs[i].awe_m, vecs[i].awe_s0, vecs[i].awe_s3);
    end

    // Asynchronous reset mid-acknowledge, asserted between clock edges.
    m_sngl = 1'b0;
    m_ie   = 1'b1;
    m_loc  = 3'd1;
    tick();
    tick();
    chk_all("pre_rst", 3'b001, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'b111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ie  = 1'b0;
    tick();
    chk_all("post_rst", 3'b111, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cascade_ctrl.md
Name: cascade_ctrl

Overview:
- Cascade-bus controller for an 8259-style PIC. One instance sits in each PIC of a master/slave chain.
- Master mode: drives the 3-bit CAS bus with the IR index of the active interrupt. It asserts its own vector-address write enable only when that IR has no slave behind it.
- Slave mode: compares CAS against its programmed ID. It asserts its vector-address write enable when CAS matches and it has a pending interrupt.
- Single mode: bypasses the cascade bus entirely.

Parameters:
- CAS_W, 3, width of the CAS bus and of the slave ID.
- IR_N, 8, number of IR lines; width of icw3 = IR_N, with IR_N = 2**CAS_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- sp  input  1  1 = master, 0 = slave.
- sngl  input  1  1 = single PIC, no cascading.
- icw3  input  8  master: bit k = 1 means a slave is on IR k; slave: [2:0] = own ID, [7:3] ignored.
- interrupt_location  input  3  IR index of the interrupt being serviced (used by the master).
- interrupt_exists  input  1  this PIC has an interrupt being acknowledged.
- cas  inout  3  cascade bus, tri-stated by default.
- address_write_enable  output  1  this PIC supplies the vector address.

Behaviour:
- All outputs are registered, with 1-cycle latency from input change to output/bus change.
- Reset (rst_n = 0, asynchronous): address_write_enable = 0; cas driver disabled (3'bzzz); any internal latch cleared.
- Single mode (sngl = 1), any sp: cas never driven; address_write_enable <= interrupt_exists.
- Master (sngl = 0, sp = 1):
  - cas_oe <= interrupt_exists.
  - cas_drv <= interrupt_location.
  - cas = cas_oe ? cas_drv : z.
  - address_write_enable <= interrupt_exists & ~icw3[interrupt_location].
  - Driving a location whose icw3 bit is 0 is harmless, because no slave owns that ID.
- Slave (sngl = 0, sp = 0):
  - Never drives cas.
  - address_write_enable <= interrupt_exists & (cas == icw3[2:0]).
  - Any X/Z bit on cas is a mismatch and yields 0. Code the compare as an if-condition whose else branch clears the flag.
- Mode inputs sp, sngl and icw3 are treated as quasi-static. A change takes effect at the next clock edge with no transient state.
- interrupt_exists falling: master releases cas and deasserts address_write_enable on the next edge.
- Reset mid-operation: the bus is released immediately, asynchronously, not at the next edge.
- Only the master drives cas. Two masters on one bus is a system error and is not detected.

Optional Feature:
- Macro CAS_LATCH_EN.
- Defined:
  - The master captures interrupt_location into a hold register on the first cycle interrupt_exists is seen high.
  - It drives that captured value, and computes address_write_enable from it, until interrupt_exists falls.
  - Location changes during an acknowledge are ignored.
  - The hold register clears on reset and when interrupt_exists is low.
- Undefined: the master follows interrupt_location every cycle, per Behaviour.

Decomposition:
- Shared package pic_pkg:
  - CAS_W and IR_N constants.
  - A cas_id_t typedef (3-bit).
  - A mode enum {MODE_SINGLE, MODE_MASTER, MODE_SLAVE} decoded from sngl/sp.
- No sub-module needed. The tri-state driver is a single continuous assignment on registered cas_drv/cas_oe; the decode and compare are inline.

Test Plan:
- Setup for all scenarios: master with icw3 = 8'b0000_1001; slave S0 with ID 0 and slave S3 with ID 3, both with interrupt_exists = 1; rst_n pulsed low then high.
- After reset with master interrupt_exists = 0 → cas = zzz, all three address_write_enable = 0.
- Master interrupt_exists = 1, interrupt_location = 0 → after 1 clk cas = 000; S0 AWE = 1; master AWE = 0; S3 AWE = 0 one clk later.
- interrupt_location = 3 → cas = 011; S3 AWE = 1; S0 AWE = 0; master AWE = 0.
- interrupt_location = 1 (no slave on IR1) → cas = 001; master AWE = 1; S0 AWE = 0; S3 AWE = 0.
- Master interrupt_exists = 0 → cas = zzz; all AWE = 0. Then assert rst_n = 0 mid-acknowledge → cas released and AWE = 0 without waiting for clk.
- sngl = 1, sp = 1, interrupt_exists = 1 → cas stays zzz and AWE = 1. With CAS_LATCH_EN defined, change location 3 → 0 mid-acknowledge → cas stays 011.
